// File: rtl/tictactoe_match_ctrl.sv
// rtl/tictactoe_match_ctrl.sv - match sequencer: round results, score pulses, board clear, match end
module tictactoe_match_ctrl #(
    parameter int WIN_TARGET = 5,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             win_x,
    input  logic             win_o,
    input  logic             draw,
    input  logic             next_round,
    output logic             inc_x,
    output logic             inc_o,
    output logic             score_reset,
    output logic             board_clear,
    output logic             start_player,
    output logic [1:0]       result,
    output logic             match_over,
    output logic             match_winner,
    output logic [CNT_W-1:0] round_count
);

    typedef enum logic [2:0] {
        PLAY    = 3'd0,
        AWARD   = 3'd1,
        SHOW    = 3'd2,
        CLEAR   = 3'd3,
        DONE    = 3'd4,
        RESTART = 3'd5
    } stateType;

    localparam logic [CNT_W-1:0] TARGET   = CNT_W'(WIN_TARGET);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_X    = 2'b01;
    localparam logic [1:0] RES_O    = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    stateType         state, nxtState;
    logic             nextRoundD;
    logic [CNT_W-1:0] winsX, winsO, nxtWinsX, nxtWinsO;
    logic [CNT_W-1:0] roundCnt, nxtRoundCnt;
    logic [1:0]       resultReg, nxtResult;
    logic             startReg, nxtStart;
    logic             winnerReg, nxtWinner;
    logic             req;

    // History starts at 1 so a button held through reset is not a request.
    assign req = next_round & ~nextRoundD;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= PLAY;
            nextRoundD <= 1'b1;
            winsX      <= '0;
            winsO      <= '0;
            roundCnt   <= CNT_ONE;
            resultReg  <= RES_NONE;
            startReg   <= 1'b0;
            winnerReg  <= 1'b0;
        end else begin
            state      <= nxtState;
            nextRoundD <= next_round;
            winsX      <= nxtWinsX;
            winsO      <= nxtWinsO;
            roundCnt   <= nxtRoundCnt;
            resultReg  <= nxtResult;
            startReg   <= nxtStart;
            winnerReg  <= nxtWinner;
        end
    end

    always_comb begin
        nxtState    = state;
        nxtWinsX    = winsX;
        nxtWinsO    = winsO;
        nxtRoundCnt = roundCnt;
        nxtResult   = resultReg;
        nxtStart    = startReg;
        nxtWinner   = winnerReg;
        case (state)
            PLAY: begin
                if (win_x) begin
                    nxtResult = RES_X;
                    nxtState  = AWARD;
                end else if (win_o) begin
                    nxtResult = RES_O;
                    nxtState  = AWARD;
                end else if (draw) begin
                    nxtResult = RES_DRAW;
                    nxtState  = SHOW;
                end
            end
            AWARD: begin
                nxtState = SHOW;
                if (resultReg == RES_X) begin
                    nxtWinsX = winsX + CNT_ONE;
                    if (nxtWinsX == TARGET) begin
                        nxtState  = DONE;
                        nxtWinner = 1'b0;
                    end
                end else begin
                    nxtWinsO = winsO + CNT_ONE;
                    if (nxtWinsO == TARGET) begin
                        nxtState  = DONE;
                        nxtWinner = 1'b1;
                    end
                end
            end
            SHOW: begin
                if (req) nxtState = CLEAR;
            end
            CLEAR: begin
                nxtStart  = ~startReg;
                nxtResult = RES_NONE;
                if (roundCnt != CNT_MAX) nxtRoundCnt = roundCnt + CNT_ONE;
                nxtState  = PLAY;
            end
            DONE: begin
                if (req) nxtState = RESTART;
            end
            RESTART: begin
                nxtWinsX    = '0;
                nxtWinsO    = '0;
                nxtStart    = 1'b0;
                nxtRoundCnt = CNT_ONE;
                nxtResult   = RES_NONE;
                nxtState    = PLAY;
            end
            default: nxtState = PLAY;
        endcase
    end

    // Pulses are pure state decodes, so a reset edge removes them immediately.
    assign inc_x        = (state == AWARD) && (resultReg == RES_X);
    assign inc_o        = (state == AWARD) && (resultReg == RES_O);
    assign score_reset  = (state == RESTART);
    assign board_clear  = (state == CLEAR) || (state == RESTART);
    assign match_over   = (state == DONE);
    assign match_winner = winnerReg;
    assign start_player = startReg;
    assign result       = resultReg;
    assign round_count  = roundCnt;

endmodule

// File: tb/tb_tictactoe_match_ctrl.sv
// tb/tb_tictactoe_match_ctrl.sv - randomized round-level check of tictactoe_match_ctrl
module tb_tictactoe_match_ctrl;

    localparam int CW   = 3;
    localparam int TGT  = 5;
    localparam int RMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, win_x, win_o, draw, next_round;
    logic          inc_x, inc_o, score_reset, board_clear, start_player;
    logic [1:0]    result;
    logic          match_over, match_winner;
    logic [CW-1:0] round_count;

    int nChecks = 0;
    int nFails  = 0;

    int mWinsX, mWinsO, mRound, mStarter, mResult, mOver, mWinner;

    tictactoe_match_ctrl #(.WIN_TARGET(TGT), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .win_x        (win_x),
        .win_o        (win_o),
        .draw         (draw),
        .next_round   (next_round),
        .inc_x        (inc_x),
        .inc_o        (inc_o),
        .score_reset  (score_reset),
        .board_clear  (board_clear),
        .start_player (start_player),
        .result       (result),
        .match_over   (match_over),
        .match_winner (match_winner),
        .round_count  (round_count)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic modelReset();
        mWinsX = 0; mWinsO = 0; mRound = 1; mStarter = 0;
        mResult = 0; mOver = 0; mWinner = 0;
    endtask

    task automatic checkSteady(input string tag);
        checkEq({tag, ".inc_x"}, 32'(inc_x), 0);
        checkEq({tag, ".inc_o"}, 32'(inc_o), 0);
        checkEq({tag, ".score_reset"}, 32'(score_reset), 0);
        checkEq({tag, ".board_clear"}, 32'(board_clear), 0);
        checkEq({tag, ".result"}, 32'(result), mResult);
        checkEq({tag, ".start_player"}, 32'(start_player), mStarter);
        checkEq({tag, ".round_count"}, 32'(round_count), mRound);
        checkEq({tag, ".match_over"}, 32'(match_over), mOver);
        if (mOver != 0) checkEq({tag, ".match_winner"}, 32'(match_winner), mWinner);
    endtask

    task automatic garbageFlags();
        win_x = 1'($urandom % 2);
        win_o = 1'($urandom % 2);
        draw  = 1'($urandom % 2);
    endtask

    task automatic doReset(input logic held);
        reset = 1'b1; win_x = 0; win_o = 0; draw = 0; next_round = held;
        step();
        step();
        reset = 1'b0;
        modelReset();
        checkSteady("reset");
    endtask

    // outcome: 0 X wins, 1 O wins, 2 both flags (X priority), 3 draw
    task automatic playRound(input int outcome, input logic preHold);
        int winner;
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
            next_round = preHold ? 1'b1 : 1'($urandom % 2);
            step();
            checkSteady("play_idle");
        end
        if (preHold) next_round = 1'b1;
        win_x = (outcome == 0) || (outcome == 2);
        win_o = (outcome == 1) || (outcome == 2);
        draw  = (outcome == 3) ? 1'b1 : 1'($urandom % 2);
        step();
        winner  = (outcome == 1) ? 1 : (outcome == 3) ? -1 : 0;
        mResult = (winner == 0) ? 1 : (winner == 1) ? 2 : 3;
        if (winner >= 0) begin
            checkEq("award.inc_x", 32'(inc_x), (winner == 0) ? 1 : 0);
            checkEq("award.inc_o", 32'(inc_o), (winner == 1) ? 1 : 0);
            checkEq("award.result", 32'(result), mResult);
            checkEq("award.board_clear", 32'(board_clear), 0);
            if (winner == 0) mWinsX++; else mWinsO++;
            if (mWinsX == TGT || mWinsO == TGT) begin
                mOver = 1;
                mWinner = winner;
            end
        end else begin
            checkSteady("draw_show");
        end
        garbageFlags();
        step();
        checkSteady("after_award");
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
            garbageFlags();
            next_round = preHold;
            step();
            checkSteady("hold");
        end
        if (preHold) begin
            next_round = 1'b0;
            step();
            checkSteady("release");
        end
        next_round = 1'b1;
        garbageFlags();
        step();
        checkEq("clear.board_clear", 32'(board_clear), 1);
        checkEq("clear.score_reset", 32'(score_reset), mOver);
        checkEq("clear.inc_x", 32'(inc_x), 0);
        checkEq("clear.inc_o", 32'(inc_o), 0);
        if (mOver != 0) checkEq("restart.match_over", 32'(match_over), 0);
        win_x = 0; win_o = 0; draw = 0;
        next_round = 1'($urandom % 2);
        step();
        if (mOver != 0) begin
            modelReset();
        end else begin
            if (mRound < RMAX) mRound++;
            mStarter ^= 1;
            mResult = 0;
        end
        checkSteady("new_round");
    endtask

    task automatic resetInAward();
        next_round = 1'b0;
        win_o = 1'b1;
        step();
        checkEq("rst_award.inc_o", 32'(inc_o), 1);
        win_o = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        modelReset();
        checkSteady("rst_award");
    endtask

    initial begin
        reset = 1'b1; win_x = 0; win_o = 0; draw = 0; next_round = 1'b1;
        modelReset();
        doReset(1'b1);
        for (int i = 0; i < 3; i++) begin
            next_round = (i != 1);
            step();
            checkSteady("held_after_reset");
        end
        playRound(0, 1'b0);
        playRound(2, 1'b0);
        playRound(3, 1'b0);
        resetInAward();
        for (int i = 0; i < TGT; i++) playRound(1, i == 2);
        for (int i = 0; i < 9; i++) playRound(3, 1'b0);
        for (int i = 0; i < 50; i++) playRound(int'($urandom % 4), ($urandom % 4) == 0);
        doReset(1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
